// File: rtl/seq_detect_prog_pkg.sv
// Shared definitions for the programmable serial-pattern detector:
// legal parameter ranges, the legacy default pattern and fill-state encoding.
package seq_detect_prog_pkg;

  // Legal parameter ranges
  localparam int SDP_PAT_LEN_MIN = 2;
  localparam int SDP_PAT_LEN_MAX = 16;
  localparam int SDP_CNT_W_MIN   = 1;
  localparam int SDP_CNT_W_MAX   = 16;

  // Legacy "111" pattern, zero-extended when PAT_LEN is larger
  localparam logic [2:0] SDP_DEFAULT_PAT = 3'b111;

  // Coarse view of the fill counter: still collecting bits, or full history
  typedef enum logic {
    ST_FILLING = 1'b0,
    ST_ARMED   = 1'b1
  } fill_state_e;

  // Width needed to hold a fill count of 0..pat_len
  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import seq_detect_prog_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_n;

  // Next count: clear first, then increment unless already at the ceiling
  always_comb begin
    w_count_n = r_count;
    if (i_clr) begin
      w_count_n = {CNT_W{1'b0}};
    end else if (i_inc && (r_count != CNT_MAX)) begin
      w_count_n = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_count_n = r_count;
    end
  end

  // Count register, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_count <= w_count_n;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable Moore serial-pattern detector. Shifts in one bit per enabled
// cycle, strobes o_z the cycle after the last PAT_LEN bits equal the loaded
// pattern, and keeps a saturating count of matches.
module seq_detect_prog
  import seq_detect_prog_pkg::*;
#(
  parameter int                 PAT_LEN     = 3,
  parameter int                 CNT_W       = 8,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(SDP_DEFAULT_PAT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_y,
  input  logic               i_overlap,
  input  logic               i_pat_ld,
  input  logic [PAT_LEN-1:0] i_pat_in,
  input  logic               i_cnt_clr,
  output logic               o_z,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_armed
);

  localparam int                FILL_W    = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  // Reject illegal configurations at elaboration
  if ((PAT_LEN < SDP_PAT_LEN_MIN) || (PAT_LEN > SDP_PAT_LEN_MAX)) begin : g_pat_len_bad
    $error("seq_detect_prog: PAT_LEN %0d outside legal range", PAT_LEN);
  end
  if ((CNT_W < SDP_CNT_W_MIN) || (CNT_W > SDP_CNT_W_MAX)) begin : g_cnt_w_bad
    $error("seq_detect_prog: CNT_W %0d outside legal range", CNT_W);
  end

  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_z;

  logic [PAT_LEN-1:0] w_pat_n;
  logic [PAT_LEN-1:0] w_hist_n;
  logic [PAT_LEN-1:0] w_hist_sh;
  logic [FILL_W-1:0]  w_fill_n;
  logic [FILL_W-1:0]  w_fill_inc;
  logic               w_hit;
  fill_state_e        w_state;

  // The fill counter is the FSM state; ARMED once the history is full
  assign w_state = (r_fill == FILL_FULL) ? ST_ARMED : ST_FILLING;

  // Next-state logic: a pattern load beats sampling, and a disabled cycle holds history
  always_comb begin
    w_pat_n    = r_pat;
    w_hist_n   = r_hist;
    w_fill_n   = r_fill;
    w_hit      = 1'b0;
    w_hist_sh  = {r_hist[PAT_LEN-2:0], i_y};
    w_fill_inc = r_fill;
    case (w_state)
      ST_ARMED:   w_fill_inc = FILL_FULL;
      ST_FILLING: w_fill_inc = r_fill + FILL_ONE;
      default:    w_fill_inc = {FILL_W{1'b0}};
    endcase
    if (i_pat_ld) begin
      // New pattern: discard history so old bits can never contribute to a match
      w_pat_n  = i_pat_in;
      w_hist_n = {PAT_LEN{1'b0}};
      w_fill_n = {FILL_W{1'b0}};
    end else if (i_en) begin
      w_hit    = (w_fill_inc == FILL_FULL) && (w_hist_sh == r_pat);
      w_hist_n = w_hist_sh;
      // Non-overlapping mode needs PAT_LEN fresh bits after every match
      if (w_hit && !i_overlap) begin
        w_fill_n = {FILL_W{1'b0}};
      end else begin
        w_fill_n = w_fill_inc;
      end
    end else begin
      w_hist_n = r_hist;
      w_fill_n = r_fill;
    end
  end

  // Detector state registers; z is a one-cycle registered strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat  <= DEFAULT_PAT;
      r_hist <= {PAT_LEN{1'b0}};
      r_fill <= {FILL_W{1'b0}};
      r_z    <= 1'b0;
    end else begin
      r_pat  <= w_pat_n;
      r_hist <= w_hist_n;
      r_fill <= w_fill_n;
      r_z    <= w_hit;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hit),
    .i_clr   (i_cnt_clr),
    .o_count (o_match_cnt)
  );

  assign o_z     = r_z;
  assign o_armed = (w_state == ST_ARMED);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Self-checking bench for seq_detect_prog: directed scenarios plus randomized
// traffic compared against a bit-list reference model.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, y, ovl, ld, clr;
  logic [2:0] pin;
  logic       z8, z2, a8, a2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of bits received since the last restart
  bit       q[$];
  bit [2:0] m_pat;
  bit       m_z;
  int       m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  seq_detect_prog #(.PAT_LEN(3), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .i_en(en), .i_y(y), .i_overlap(ovl), .i_pat_ld(ld),
    .i_pat_in(pin), .i_cnt_clr(clr), .o_z(z8), .o_match_cnt(cnt8), .o_armed(a8));

  seq_detect_prog #(.PAT_LEN(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .i_en(en), .i_y(y), .i_overlap(ovl), .i_pat_ld(ld),
    .i_pat_in(pin), .i_cnt_clr(clr), .o_z(z2), .o_match_cnt(cnt2), .o_armed(a2));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pat  = 3'b111;
    m_z    = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  // Apply the behaviour of one rising edge using the inputs currently driven
  task automatic model_edge();
    bit hit;
    hit = 1'b0;
    if (ld) begin
      m_pat = pin;
      q.delete();
    end else if (en) begin
      q.push_back(y);
      if (q.size() > 3) void'(q.pop_front());
      if (q.size() == 3) hit = ({q[0], q[1], q[2]} == m_pat);
      if (hit && !ovl) q.delete();
    end
    m_z = hit;
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_z8"},   z8,   m_z);
    check_val({tag, "_z2"},   z2,   m_z);
    check_val({tag, "_cnt8"}, cnt8, m_cnt8);
    check_val({tag, "_cnt2"}, cnt2, m_cnt2);
    check_val({tag, "_arm8"}, a8,   (q.size() == 3));
    check_val({tag, "_arm2"}, a2,   (q.size() == 3));
  endtask

  task automatic step(input string tag, input bit s_ld, input bit [2:0] s_pin,
                      input bit s_en, input bit s_y, input bit s_ovl, input bit s_clr);
    @(negedge clk);
    ld = s_ld; pin = s_pin; en = s_en; y = s_y; ovl = s_ovl; clr = s_clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    ld = 1'b0; pin = 3'b000; en = 1'b0; y = 1'b0; ovl = 1'b0; clr = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit t1_bits [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit t3_bits [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit t3_z    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int zc;

    rst = 1'b0;
    ld = 1'b0; pin = 3'b000; en = 1'b0; y = 1'b0; ovl = 1'b0; clr = 1'b0;
    model_reset();
    #12;
    check_val("rst_z",   z8,   1'b0);
    check_val("rst_cnt", cnt8, 8'd0);
    check_val("rst_arm", a8,   1'b0);
    @(negedge clk);
    rst = 1'b1;

    // T1: legacy 111 behaviour, non-overlapping
    zc = 0;
    for (int i = 0; i < 7; i++) begin
      step("t1", 1'b0, 3'b000, 1'b1, t1_bits[i], 1'b0, 1'b0);
      if (z8) zc++;
      if (i == 3 || i == 6) check_val("t1_zhit", z8, 1'b1);
    end
    check_val("t1_zcount", zc, 2);
    check_val("t1_cnt", cnt8, 8'd2);

    // T2: same stream, overlapping
    do_reset();
    zc = 0;
    for (int i = 0; i < 7; i++) begin
      step("t2", 1'b0, 3'b000, 1'b1, t1_bits[i], 1'b1, 1'b0);
      if (z8) zc++;
    end
    check_val("t2_zcount", zc, 4);
    check_val("t2_cnt", cnt8, 8'd4);

    // T3: load 101 mid-stream (history full of ones), then 1,0,1,0,1
    step("t3ld", 1'b1, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("t3_arm_ld", a8, 1'b0);
    check_val("t3_z_ld", z8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("t3", 1'b0, 3'b000, 1'b1, t3_bits[i], 1'b1, 1'b0);
      check_val("t3_zseq", z8, t3_z[i]);
      if (i < 2) check_val("t3_arm_fill", a8, 1'b0);
    end

    // T4: enable gaps between pattern bits
    step("t4ld", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
    zc = 0;
    step("t4", 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("t4off", 1'b0, 3'b000, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check_val("t4_z_en0", z8, 1'b0);
    end
    step("t4", 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    if (z8) zc++;
    step("t4", 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    if (z8) zc++;
    check_val("t4_zcount", zc, 1);

    // T5: saturation of a 2-bit counter, then clear against a hit
    do_reset();
    for (int i = 0; i < 7; i++) step("t5", 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("t5_sat2", cnt2, 2'd3);
    check_val("t5_cnt8", cnt8, 8'd5);
    step("t5clr", 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1);
    check_val("t5_clr_z", z8, 1'b1);
    check_val("t5_clr_cnt", cnt2, 2'd0);

    // T6: asynchronous reset while z is high and the history is full
    do_reset();
    for (int i = 0; i < 3; i++) step("t6", 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("t6_zpre", z8, 1'b1);
    check_val("t6_armpre", a8, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_z", z8, 1'b0);
    check_val("t6_arm", a8, 1'b0);
    check_val("t6_cnt", cnt8, 8'd0);
    model_reset();
    ld = 1'b0; en = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 99) < 3), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
